pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Owns the program counter and sequences pipeline stall/flush control for the fetch, decode and execute stages. Redirect requests arrive from the branch unit's decode-stage path (JAL, predicted-taken conditional) and execute-stage path (JALR, mispredict recovery), alongside load-use and memory-wait hazards. The block arbitrates them by fixed priority, updates the PC, and runs a small FSM to cover instruction-memory wait after a redirect and load-use bubble insertion. Saturating counters record redirects and bubbles for performance analysis.

## Interface

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of each performance counter.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- imemReady  in  1  instruction memory returns valid data for the current `pc` this cycle.
- memBusy  in  1  data memory stall; freezes the whole pipeline.
- loadUse  in  1  decode-stage instruction depends on the load in execute.
- decRedirect  in  1  decode-stage redirect request (JAL or predicted-taken branch).
- decTarget  in  32  target for decRedirect.
- exeRedirect  in  1  execute-stage redirect request (JALR or mispredict).
- exeTarget  in  32  target for exeRedirect.
- pc  out  32  current fetch address (registered).
- ifStall  out  1  hold the IF/DEC pipeline register.
- decStall  out  1  hold the DEC/EXE pipeline register.
- exeStall  out  1  hold the EXE/MEM pipeline register.
- ifFlush  out  1  load a bubble into the IF/DEC register.
- decFlush  out  1  load a bubble into the DEC/EXE register.
- misalign  out  1  one-cycle pulse: the accepted redirect target had bits [1:0] != 0.
- redirectCount  out  CNT_W  accepted redirects, saturating.
- bubbleCount  out  CNT_W  load-use bubbles inserted, saturating.

## Operation

- States: RUN, REDIRECT, LOAD_BUBBLE. All outputs except `pc` and the counters are combinational from state and inputs.
- Evaluation order is memBusy, then exeRedirect, then decRedirect, then loadUse.
  - A higher-priority event masks every lower one.
- memBusy=1, in any state:
  - ifStall=decStall=exeStall=1, flushes 0.
  - No PC update, no state change, no counter update.
  - Upstream holds its requests while frozen.
- exeRedirect=1, in any state:
  - pc <= {exeTarget[31:2],2'b00}; ifFlush=decFlush=1.
  - redirectCount+1; misalign=|exeTarget[1:0].
  - Next state is REDIRECT.
- decRedirect=1, in RUN or LOAD_BUBBLE:
  - pc <= {decTarget[31:2],2'b00}; ifFlush=1, decFlush=0.
  - redirectCount+1; misalign=|decTarget[1:0].
  - Next state is REDIRECT.
  - decRedirect is ignored in REDIRECT, because decode holds a bubble in that state.
- loadUse=1, in RUN only:
  - ifStall=1 (PC held); decFlush=1.
  - bubbleCount+1; next state is LOAD_BUBBLE.
- LOAD_BUBBLE:
  - loadUse is ignored.
  - If there is no redirect, behaves as RUN without a hazard, then returns to RUN.
- REDIRECT:
  - While imemReady=0: ifFlush=1, PC held.
  - On imemReady=1: pc <= pc+4, ifFlush=0, return to RUN.
- RUN with no event:
  - If imemReady=1, pc <= pc+4.
  - If imemReady=0, PC held and ifFlush=1.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC becomes 0).
  - Counters stop at all ones.
- Reset state:
  - pc=RESET_VECTOR, state RUN, counters 0, misalign 0.
  - While nReset=0: ifFlush=decFlush=1, all stalls 0.

## Timing

- A redirect asserted in cycle N updates `pc` to the target at the rising edge ending cycle N, so it is visible in cycle N+1.
  - Flushes are asserted in cycle N itself.
- Redirect penalty is 1 cycle with imemReady=1 throughout: REDIRECT lasts one cycle, then RUN.
- A load-use bubble costs exactly 1 cycle. Back-to-back loadUse produces one bubble per two cycles.
- If exeRedirect and decRedirect arrive in the same cycle, exeTarget wins. decRedirect is dropped, not queued.
- Reset mid-operation aborts any state immediately (asynchronous). The first fetch after release is RESET_VECTOR.

## Test plan

- Reset with RESET_VECTOR=32'h100 and imemReady=1, idle for 3 cycles -> pc=0x100, then 0x104, 0x108, 0x10C; all stalls 0; counters 0.
- At pc=0x200, decRedirect=1 with decTarget=0x80 for one cycle -> ifFlush=1 that cycle; next pc=0x80, then 0x84; redirectCount=1.
- decRedirect (0x80) and exeRedirect (0x400) in the same cycle -> ifFlush=decFlush=1; next pc=0x400; redirectCount=1.
- loadUse held high for 4 cycles from pc=0x10 -> decFlush pulses on cycles 1 and 3; pc held on those cycles; bubbleCount=2.
- exeRedirect to 0x302 while memBusy=1 for 2 cycles, then memBusy=0 -> no pc change and all stalls 1 while frozen; then pc=0x300 and misalign pulses once.
- Force redirectCount to 0xFFFF, then issue a redirect -> count stays 0xFFFF. Separately, pc=0xFFFFFFFC with imemReady=1 -> next pc=0x0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch/redirect/hazard handshake bundle between the pipeline and the PC sequencer.
// The master side raises requests; the slave (the sequencer) returns PC, stall/flush and counters.
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic              imemReady;
    logic              memBusy;
    logic              loadUse;
    logic              decRedirect;
    logic [31:0]       decTarget;
    logic              exeRedirect;
    logic [31:0]       exeTarget;
    logic [31:0]       pc;
    logic              ifStall;
    logic              decStall;
    logic              exeStall;
    logic              ifFlush;
    logic              decFlush;
    logic              misalign;
    logic [CNT_W-1:0]  redirectCount;
    logic [CNT_W-1:0]  bubbleCount;

    modport master (
        output imemReady, memBusy, loadUse, decRedirect, decTarget, exeRedirect, exeTarget,
        input  pc, ifStall, decStall, exeStall, ifFlush, decFlush, misalign,
               redirectCount, bubbleCount
    );

    modport slave (
        input  imemReady, memBusy, loadUse, decRedirect, decTarget, exeRedirect, exeTarget,
        output pc, ifStall, decStall, exeStall, ifFlush, decFlush, misalign,
               redirectCount, bubbleCount
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: arbitrates redirects and hazards by fixed priority, drives
// pipeline stall/flush controls, and keeps saturating redirect/bubble counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16
) (
    input  logic           Clock,
    input  logic           nReset,
    pc_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {RUN, REDIRECT, LOAD_BUBBLE} state_t;

    state_t            state, nextState;
    logic [31:0]       pcReg, nextPc;
    logic [CNT_W-1:0]  redirectCnt, bubbleCnt;
    logic              incRedirect, incBubble;
    logic              ifStall, decStall, exeStall, ifFlush, decFlush, misalign;

    // Priority: memBusy > exeRedirect > decRedirect > loadUse > normal fetch.
    always_comb begin
        nextState   = state;
        nextPc      = pcReg;
        incRedirect = 1'b0;
        incBubble   = 1'b0;
        ifStall     = 1'b0;
        decStall    = 1'b0;
        exeStall    = 1'b0;
        ifFlush     = 1'b0;
        decFlush    = 1'b0;
        misalign    = 1'b0;
        if (!nReset) begin
            ifFlush  = 1'b1;
            decFlush = 1'b1;
        end else if (bus.memBusy) begin
            ifStall  = 1'b1;
            decStall = 1'b1;
            exeStall = 1'b1;
        end else if (bus.exeRedirect) begin
            nextPc      = {bus.exeTarget[31:2], 2'b00};
            nextState   = REDIRECT;
            ifFlush     = 1'b1;
            decFlush    = 1'b1;
            incRedirect = 1'b1;
            misalign    = |bus.exeTarget[1:0];
        end else if (bus.decRedirect && state != REDIRECT) begin
            nextPc      = {bus.decTarget[31:2], 2'b00};
            nextState   = REDIRECT;
            ifFlush     = 1'b1;
            incRedirect = 1'b1;
            misalign    = |bus.decTarget[1:0];
        end else if (bus.loadUse && state == RUN) begin
            nextState = LOAD_BUBBLE;
            ifStall   = 1'b1;
            decFlush  = 1'b1;
            incBubble = 1'b1;
        end else if (bus.imemReady) begin
            nextPc    = pcReg + 32'd4;
            nextState = RUN;
        end else begin
            // REDIRECT keeps waiting for the target fetch; LOAD_BUBBLE drops back to RUN.
            ifFlush = 1'b1;
            if (state == LOAD_BUBBLE) begin
                nextState = RUN;
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= RUN;
            pcReg       <= RESET_VECTOR;
            redirectCnt <= '0;
            bubbleCnt   <= '0;
        end else begin
            state <= nextState;
            pcReg <= nextPc;
            if (incRedirect && redirectCnt != '1) begin
                redirectCnt <= redirectCnt + 1'b1;
            end
            if (incBubble && bubbleCnt != '1) begin
                bubbleCnt <= bubbleCnt + 1'b1;
            end
        end
    end

    assign bus.pc            = pcReg;
    assign bus.ifStall       = ifStall;
    assign bus.decStall      = decStall;
    assign bus.exeStall      = exeStall;
    assign bus.ifFlush       = ifFlush;
    assign bus.decFlush      = decFlush;
    assign bus.misalign      = misalign;
    assign bus.redirectCount = redirectCnt;
    assign bus.bubbleCount   = bubbleCnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized run against a
// behavioural model of the redirect/hazard rules.
module tb_pc_sequencer;
    logic Clock;
    logic nReset;
    int   tests;
    int   fails;

    pc_sequencer_if #(.CNT_W(16)) busA ();
    pc_sequencer_if #(.CNT_W(3))  busS ();

    pc_sequencer #(.RESET_VECTOR(32'h100), .CNT_W(16)) dutA (
        .Clock (Clock),
        .nReset(nReset),
        .bus   (busA.slave)
    );

    pc_sequencer #(.RESET_VECTOR(32'h0), .CNT_W(3)) dutS (
        .Clock (Clock),
        .nReset(nReset),
        .bus   (busS.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Control vector order: {ifStall, decStall, exeStall, ifFlush, decFlush, misalign}
    function automatic logic [5:0] ctrlA();
        return {busA.ifStall, busA.decStall, busA.exeStall, busA.ifFlush, busA.decFlush, busA.misalign};
    endfunction

    task automatic clearInputs();
        busA.imemReady = 1'b0; busA.memBusy = 1'b0; busA.loadUse = 1'b0;
        busA.decRedirect = 1'b0; busA.decTarget = '0;
        busA.exeRedirect = 1'b0; busA.exeTarget = '0;
        busS.imemReady = 1'b0; busS.memBusy = 1'b0; busS.loadUse = 1'b0;
        busS.decRedirect = 1'b0; busS.decTarget = '0;
        busS.exeRedirect = 1'b0; busS.exeTarget = '0;
    endtask

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyReset();
        clearInputs();
        nReset = 1'b0;
        cycle();
        nReset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        nReset = 1'b0;
        cycle();
        tests++;
        if (ctrlA() !== 6'b000110) begin
            fails++; $display("FAIL reset_ctrl: got %b expected %b", ctrlA(), 6'b000110);
        end
        tests++;
        if (busA.pc !== 32'h100) begin
            fails++; $display("FAIL reset_pc: got %h expected %h", busA.pc, 32'h100);
        end
        nReset = 1'b1;
        busA.imemReady = 1'b1;
        #1;
        tests++;
        if (ctrlA() !== 6'b000000 || busA.redirectCount !== 16'd0 || busA.bubbleCount !== 16'd0) begin
            fails++; $display("FAIL reset_idle: ctrl %b rc %0d bc %0d expected 000000 0 0",
                              ctrlA(), busA.redirectCount, busA.bubbleCount);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle();
            tests++;
            if (busA.pc !== 32'h100 + 32'(4 * i)) begin
                fails++; $display("FAIL reset_seq%0d: got %h expected %h", i, busA.pc, 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_dec_redirect();
        applyReset();
        busA.imemReady = 1'b1;
        repeat (64) cycle();
        tests++;
        if (busA.pc !== 32'h200) begin
            fails++; $display("FAIL dec_start_pc: got %h expected %h", busA.pc, 32'h200);
        end
        busA.decRedirect = 1'b1;
        busA.decTarget   = 32'h80;
        #1;
        tests++;
        if (ctrlA() !== 6'b000100) begin
            fails++; $display("FAIL dec_ctrl: got %b expected %b", ctrlA(), 6'b000100);
        end
        cycle();
        busA.decRedirect = 1'b0;
        tests++;
        if (busA.pc !== 32'h80) begin
            fails++; $display("FAIL dec_target: got %h expected %h", busA.pc, 32'h80);
        end
        cycle();
        tests++;
        if (busA.pc !== 32'h84 || busA.redirectCount !== 16'd1) begin
            fails++; $display("FAIL dec_after: pc %h rc %0d expected 00000084 1", busA.pc, busA.redirectCount);
        end
    endtask

    task automatic test_same_cycle();
        applyReset();
        busA.imemReady   = 1'b1;
        busA.decRedirect = 1'b1; busA.decTarget = 32'h80;
        busA.exeRedirect = 1'b1; busA.exeTarget = 32'h400;
        #1;
        tests++;
        if (ctrlA() !== 6'b000110) begin
            fails++; $display("FAIL both_ctrl: got %b expected %b", ctrlA(), 6'b000110);
        end
        cycle();
        busA.decRedirect = 1'b0; busA.exeRedirect = 1'b0;
        tests++;
        if (busA.pc !== 32'h400 || busA.redirectCount !== 16'd1) begin
            fails++; $display("FAIL both_pc: pc %h rc %0d expected 00000400 1", busA.pc, busA.redirectCount);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] expPc [4];
        expPc = '{32'h10, 32'h14, 32'h14, 32'h18};
        applyReset();
        busA.imemReady   = 1'b1;
        busA.exeRedirect = 1'b1; busA.exeTarget = 32'hC;
        cycle();
        busA.exeRedirect = 1'b0;
        cycle();
        tests++;
        if (busA.pc !== 32'h10) begin
            fails++; $display("FAIL lu_start_pc: got %h expected %h", busA.pc, 32'h10);
        end
        busA.loadUse = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (busA.decFlush !== (i % 2 == 0) || busA.ifStall !== (i % 2 == 0)) begin
                fails++; $display("FAIL lu_ctrl%0d: decFlush %b ifStall %b expected %b", i + 1,
                                  busA.decFlush, busA.ifStall, (i % 2 == 0));
            end
            cycle();
            tests++;
            if (busA.pc !== expPc[i]) begin
                fails++; $display("FAIL lu_pc%0d: got %h expected %h", i + 1, busA.pc, expPc[i]);
            end
        end
        busA.loadUse = 1'b0;
        tests++;
        if (busA.bubbleCount !== 16'd2) begin
            fails++; $display("FAIL lu_count: got %0d expected 2", busA.bubbleCount);
        end
    endtask

    task automatic test_mem_busy();
        applyReset();
        busA.imemReady   = 1'b1;
        busA.memBusy     = 1'b1;
        busA.exeRedirect = 1'b1; busA.exeTarget = 32'h302;
        repeat (2) begin
            #1;
            tests++;
            if (ctrlA() !== 6'b111000) begin
                fails++; $display("FAIL busy_ctrl: got %b expected %b", ctrlA(), 6'b111000);
            end
            cycle();
            tests++;
            if (busA.pc !== 32'h100 || busA.redirectCount !== 16'd0) begin
                fails++; $display("FAIL busy_hold: pc %h rc %0d expected 00000100 0", busA.pc, busA.redirectCount);
            end
        end
        busA.memBusy = 1'b0;
        #1;
        tests++;
        if (ctrlA() !== 6'b000111) begin
            fails++; $display("FAIL busy_release_ctrl: got %b expected %b", ctrlA(), 6'b000111);
        end
        cycle();
        busA.exeRedirect = 1'b0;
        #1;
        tests++;
        if (busA.pc !== 32'h300 || ctrlA() !== 6'b000000 || busA.redirectCount !== 16'd1) begin
            fails++; $display("FAIL busy_after: pc %h ctrl %b rc %0d expected 00000300 000000 1",
                              busA.pc, ctrlA(), busA.redirectCount);
        end
    endtask

    task automatic test_saturation();
        applyReset();
        busS.imemReady   = 1'b1;
        busS.exeRedirect = 1'b1; busS.exeTarget = 32'h40;
        repeat (9) cycle();
        busS.exeRedirect = 1'b0;
        tests++;
        if (busS.redirectCount !== 3'd7) begin
            fails++; $display("FAIL sat_redirect: got %0d expected 7", busS.redirectCount);
        end
        cycle();
        busS.loadUse = 1'b1;
        repeat (20) cycle();
        busS.loadUse = 1'b0;
        tests++;
        if (busS.bubbleCount !== 3'd7) begin
            fails++; $display("FAIL sat_bubble: got %0d expected 7", busS.bubbleCount);
        end
    endtask

    task automatic test_pc_wrap();
        applyReset();
        busS.imemReady   = 1'b1;
        busS.exeRedirect = 1'b1; busS.exeTarget = 32'hFFFF_FFF8;
        cycle();
        busS.exeRedirect = 1'b0;
        cycle();
        tests++;
        if (busS.pc !== 32'hFFFF_FFFC) begin
            fails++; $display("FAIL wrap_pre: got %h expected %h", busS.pc, 32'hFFFF_FFFC);
        end
        cycle();
        tests++;
        if (busS.pc !== 32'h0) begin
            fails++; $display("FAIL wrap_zero: got %h expected %h", busS.pc, 32'h0);
        end
    endtask

    // Randomized run: model tracks only "fetch pending after redirect" and
    // "bubble just inserted", deriving everything else from the arbitration rules.
    task automatic test_random();
        logic [31:0] mPc;
        bit          afterRedirect, afterBubble, rst;
        int unsigned mRc, mBc;
        logic [5:0]  expCtrl;
        logic [31:0] expNext;
        applyReset();
        mPc = 32'h100; afterRedirect = 0; afterBubble = 0; mRc = 0; mBc = 0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            busA.imemReady   = ($urandom_range(0, 3) != 0);
            busA.memBusy     = ($urandom_range(0, 9) == 0);
            busA.loadUse     = ($urandom_range(0, 3) == 0);
            busA.decRedirect = ($urandom_range(0, 7) == 0);
            busA.exeRedirect = ($urandom_range(0, 9) == 0);
            busA.decTarget   = $urandom;
            busA.exeTarget   = $urandom;
            nReset = !rst;
            expNext = mPc;
            if (rst) begin
                expCtrl = 6'b000110;
                mPc = 32'h100; expNext = 32'h100;
                afterRedirect = 0; afterBubble = 0; mRc = 0; mBc = 0;
            end else if (busA.memBusy) begin
                expCtrl = 6'b111000;
            end else if (busA.exeRedirect || (busA.decRedirect && !afterRedirect)) begin
                logic [31:0] t;
                t = busA.exeRedirect ? busA.exeTarget : busA.decTarget;
                expCtrl = {3'b000, 1'b1, busA.exeRedirect, t[1:0] != 2'b00};
                expNext = t & 32'hFFFF_FFFC;
                afterRedirect = 1; afterBubble = 0;
                if (mRc < 65535) mRc++;
            end else if (busA.loadUse && !afterRedirect && !afterBubble) begin
                expCtrl = 6'b100010;
                afterBubble = 1;
                if (mBc < 65535) mBc++;
            end else if (busA.imemReady) begin
                expCtrl = 6'b000000;
                expNext = mPc + 32'd4;
                afterRedirect = 0; afterBubble = 0;
            end else begin
                expCtrl = 6'b000100;
                afterBubble = 0;
            end
            #1;
            tests++;
            if (ctrlA() !== expCtrl || busA.pc !== mPc) begin
                fails++; $display("FAIL rand_ctrl[%0d]: ctrl %b pc %h expected %b %h", n, ctrlA(), busA.pc, expCtrl, mPc);
            end
            cycle();
            mPc = expNext;
            tests++;
            if (busA.pc !== mPc || busA.redirectCount !== 16'(mRc) || busA.bubbleCount !== 16'(mBc)) begin
                fails++; $display("FAIL rand_state[%0d]: pc %h rc %0d bc %0d expected %h %0d %0d",
                                  n, busA.pc, busA.redirectCount, busA.bubbleCount, mPc, mRc, mBc);
            end
        end
        nReset = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_dec_redirect();
        test_same_cycle();
        test_load_use();
        test_mem_busy();
        test_saturation();
        test_pc_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
